// File: rtl/keycode_report_builder.sv
// WASD key scanner: synchronize, debounce, keep a press-ordered
// keycode list and publish it as a coalescing valid/ready report.
module keycode_report_builder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [3:0]  key_in,
  output logic [31:0] keycode,
  output logic        keycode_valid,
  input  logic        keycode_ready,
  output logic [3:0]  pressed
);

  localparam logic [7:0] LIM = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [7:0]  cnt [4];
  logic [31:0] list_q;
  logic [31:0] list_d;
  logic [31:0] list_sh;
  logic [3:0]  listed;
  logic [3:0]  listed_d;
  logic [3:0]  rel;
  logic [3:0]  prs;
  logic [1:0]  sel;
  logic [1:0]  pos;
  logic        found;
  logic        hit;
  logic [7:0]  code;

  function automatic logic [7:0] code_of(input logic [1:0] k);
    logic [7:0] c;
    unique case (k)
      2'd3: c = 8'h1A;
      2'd2: c = 8'h04;
      2'd1: c = 8'h16;
      2'd0: c = 8'h07;
    endcase
    return c;
  endfunction

  // Two-flop synchronizer and per-key debounce counters.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1      <= '0;
      s2      <= '0;
      pressed <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != pressed[i]) begin
          if (cnt[i] == LIM) begin
            pressed[i] <= ~pressed[i];
            cnt[i]     <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign rel     = listed & ~pressed;
  assign prs     = pressed & ~listed;
  assign list_sh = list_q >> 8;

  // One list edit per cycle: lowest released key, else lowest new press.
  always_comb begin
    list_d   = list_q;
    listed_d = listed;
    sel      = '0;
    pos      = '0;
    found    = 1'b0;
    hit      = 1'b0;
    code     = '0;
    if (|rel) begin
      for (int i = 0; i < 4; i++) begin
        if (rel[i] && !found) begin
          sel   = 2'(i);
          found = 1'b1;
        end
      end
      code = code_of(sel);
      for (int j = 0; j < 4; j++) begin
        if (!hit && list_q[8*j +: 8] == code) begin
          pos = 2'(j);
          hit = 1'b1;
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (2'(j) >= pos) list_d[8*j +: 8] = list_sh[8*j +: 8];
      end
      listed_d[sel] = 1'b0;
    end else if (|prs) begin
      for (int i = 0; i < 4; i++) begin
        if (prs[i] && !found) begin
          sel   = 2'(i);
          found = 1'b1;
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (!hit && list_q[8*j +: 8] == 8'h00) begin
          pos = 2'(j);
          hit = 1'b1;
        end
      end
      code = code_of(sel);
      list_d[{pos, 3'b000} +: 8] = code;
      listed_d[sel] = 1'b1;
    end
  end

  // Working list register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      list_q <= '0;
      listed <= '0;
    end else begin
      list_q <= list_d;
      listed <= listed_d;
    end
  end

  // Report slot: load when free or transferring, newest list wins.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      keycode       <= '0;
      keycode_valid <= 1'b0;
    end else if ((!keycode_valid || keycode_ready) && list_q != keycode) begin
      keycode       <= list_q;
      keycode_valid <= 1'b1;
    end else if (keycode_ready) begin
      keycode_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keycode_report_builder.sv
// Bench for keycode_report_builder: vector table, corner sequences,
// and random stimulus against a queue-based reference model.
module tb_keycode_report_builder;

  localparam int DEB = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [3:0]  key_in;
  logic [31:0] keycode;
  logic        keycode_valid;
  logic        keycode_ready;
  logic [3:0]  pressed;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] mq1, mq2, mp;
  int         run [4];
  logic [7:0] mlist [$];
  logic [31:0] mk;
  logic        mv;

  typedef struct {
    logic [3:0]  key;
    logic        rdy;
    int          cyc;
    logic [31:0] kc;
    logic        v;
    logic [3:0]  p;
  } vec_t;

  vec_t tbl [$];

  always #5 Clk = ~Clk;

  keycode_report_builder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .key_in        (key_in),
    .keycode       (keycode),
    .keycode_valid (keycode_valid),
    .keycode_ready (keycode_ready),
    .pressed       (pressed)
  );

  function automatic logic [7:0] code_of(input int k);
    case (k)
      3: return 8'h1A;
      2: return 8'h04;
      1: return 8'h16;
      default: return 8'h07;
    endcase
  endfunction

  function automatic logic [31:0] pack_list();
    logic [31:0] w = '0;
    for (int j = 0; j < mlist.size(); j++)
      w = w | (32'(mlist[j]) << (8 * j));
    return w;
  endfunction

  function automatic int find_code(input logic [7:0] c);
    int idx = -1;
    for (int j = 0; j < mlist.size(); j++)
      if (mlist[j] == c) idx = j;
    return idx;
  endfunction

  task automatic model_edge();
    logic [31:0] lw;
    bit done;
    int idx;
    if (!Reset_n) begin
      mq1 = '0; mq2 = '0; mp = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      mlist.delete();
      mk = '0; mv = 1'b0;
    end else begin
      lw = pack_list();
      if ((!mv || keycode_ready) && lw != mk) begin
        mk = lw; mv = 1'b1;
      end else if (mv && keycode_ready) begin
        mv = 1'b0;
      end
      done = 0;
      for (int i = 0; i < 4; i++) begin
        idx = find_code(code_of(i));
        if (!done && idx >= 0 && !mp[i]) begin
          mlist.delete(idx);
          done = 1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!done && mp[i] && find_code(code_of(i)) < 0) begin
          mlist.push_back(code_of(i));
          done = 1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (mq2[i] != mp[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            mp[i] = ~mp[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      mq2 = mq1;
      mq1 = key_in;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("model_keycode", keycode, mk);
    chk("model_valid", {31'b0, keycode_valid}, {31'b0, mv});
    chk("model_pressed", {28'b0, pressed}, {28'b0, mp});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_out(input string name, input logic [31:0] kc,
                         input logic v, input logic [3:0] p);
    chk({name, "_keycode"}, keycode, kc);
    chk({name, "_valid"}, {31'b0, keycode_valid}, {31'b0, v});
    chk({name, "_pressed"}, {28'b0, pressed}, {28'b0, p});
  endtask

  initial begin
    logic [31:0] sim_exp [4];
    mq1 = '0; mq2 = '0; mp = '0; mk = '0; mv = 1'b0;
    for (int i = 0; i < 4; i++) run[i] = 0;

    tbl.push_back('{4'b1000, 1'b0, 7,  32'h0,        1'b0, 4'b1000});
    tbl.push_back('{4'b1000, 1'b0, 1,  32'h0000001A, 1'b1, 4'b1000});
    tbl.push_back('{4'b1000, 1'b0, 20, 32'h0000001A, 1'b1, 4'b1000});
    tbl.push_back('{4'b1000, 1'b1, 1,  32'h0000001A, 1'b0, 4'b1000});
    tbl.push_back('{4'b1100, 1'b1, 8,  32'h0000041A, 1'b1, 4'b1100});
    tbl.push_back('{4'b1100, 1'b1, 12, 32'h0000041A, 1'b0, 4'b1100});
    tbl.push_back('{4'b1101, 1'b1, 20, 32'h0007041A, 1'b0, 4'b1101});
    tbl.push_back('{4'b1001, 1'b1, 20, 32'h0000071A, 1'b0, 4'b1001});
    tbl.push_back('{4'b0000, 1'b1, 20, 32'h00000000, 1'b0, 4'b0000});

    Reset_n = 1'b0; key_in = '0; keycode_ready = 1'b0;
    steps(2);
    chk_out("reset", 32'h0, 1'b0, 4'h0);
    Reset_n = 1'b1;
    steps(3);
    chk_out("idle_after_reset", 32'h0, 1'b0, 4'h0);

    // vector table: backpressure, ordered presses, release
    for (int t = 0; t < tbl.size(); t++) begin
      key_in = tbl[t].key;
      keycode_ready = tbl[t].rdy;
      steps(tbl[t].cyc);
      chk_out($sformatf("vec%0d", t), tbl[t].kc, tbl[t].v, tbl[t].p);
    end

    // glitch shorter than the debounce window
    keycode_ready = 1'b0;
    key_in = 4'b1000;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) key_in = 4'b0000;
      step();
      chk_out("glitch", 32'h0, 1'b0, 4'h0);
    end

    // simultaneous press, one list edit per cycle
    keycode_ready = 1'b1;
    key_in = 4'b1111;
    steps(7);
    sim_exp[0] = 32'h00000007;
    sim_exp[1] = 32'h00001607;
    sim_exp[2] = 32'h00041607;
    sim_exp[3] = 32'h1A041607;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("simul%0d", i), sim_exp[i], 1'b1, 4'hF);
    end
    step();
    chk_out("simul_done", 32'h1A041607, 1'b0, 4'hF);
    key_in = 4'b0000;
    steps(20);
    chk_out("simul_release", 32'h0, 1'b0, 4'h0);

    // coalescing under backpressure
    keycode_ready = 1'b0;
    key_in = 4'b1000;
    steps(8);
    chk_out("coal_press", 32'h1A, 1'b1, 4'b1000);
    key_in = 4'b0000;
    steps(10);
    chk_out("coal_held", 32'h1A, 1'b1, 4'b0000);
    keycode_ready = 1'b1;
    step();
    chk_out("coal_xfer1", 32'h0, 1'b1, 4'b0000);
    step();
    chk_out("coal_xfer2", 32'h0, 1'b0, 4'b0000);

    // reset while a report is pending
    keycode_ready = 1'b0;
    key_in = 4'b1000;
    steps(8);
    chk_out("rst_pending", 32'h1A, 1'b1, 4'b1000);
    Reset_n = 1'b0;
    step();
    chk_out("rst_clear", 32'h0, 1'b0, 4'h0);
    Reset_n = 1'b1;
    steps(7);
    chk_out("rst_wait", 32'h0, 1'b0, 4'b1000);
    step();
    chk_out("rst_rereport", 32'h1A, 1'b1, 4'b1000);
    key_in = 4'b0000;
    keycode_ready = 1'b1;
    steps(20);
    chk_out("rst_release", 32'h0, 1'b0, 4'h0);

    // random stimulus against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0)
        key_in = key_in ^ (4'b0001 << $urandom_range(0, 3));
      keycode_ready = ($urandom_range(0, 3) != 0);
      Reset_n = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
